// File: rtl/board_grid.sv
// Playfield storage for a falling-block game: per-cell color and occupancy,
// cell writes from the piece logic, a combinational collision query, and a
// bottom-up line-clear scan that removes full rows after each piece locks.
module board_grid #(
  parameter int COLS = 10,
  parameter int ROWS = 18,
  parameter int CW   = 3
) (
  input  logic                                vga_clk,
  input  logic                                reset_n,
  input  logic                                clr,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [3:0]                          wr_x,
  input  logic [4:0]                          wr_y,
  input  logic [CW-1:0]                       wr_color,
  input  logic                                lock_done,
  input  logic [3:0]                          q_x,
  input  logic [4:0]                          q_y,
  output logic                                q_occ,
  output logic                                busy,
  output logic                                clear_done,
  output logic [4:0]                          lines_cleared,
  output logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid,
  output logic [ROWS-1:0][COLS-1:0]           occ
);

  localparam logic [3:0] COLS_L   = 4'(COLS);
  localparam logic [4:0] ROWS_L   = 5'(ROWS);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t                             state_q, state_d;
  logic [4:0]                         r_q, r_d;
  logic [4:0]                         count_q, count_d;
  logic [4:0]                         lines_q, lines_d;
  logic                               clear_done_q, clear_done_d;
  logic [ROWS-1:0][COLS-1:0][CW-1:0]  grid_q;
  logic [ROWS-1:0][COLS-1:0]          occ_q;

  logic row_full;
  logic wr_fire;

  // The row under the scan pointer is complete when every occupancy bit is set.
  assign row_full = &occ_q[r_q];

  // Writes land only while idle, in range, and not overridden by a wipe.
  assign wr_fire  = (state_q == IDLE) && wr_valid && (wr_x < COLS_L) &&
                    (wr_y < ROWS_L) && !clr;

  assign busy          = (state_q != IDLE);
  assign wr_ready      = ~busy;
  assign clear_done    = clear_done_q;
  assign lines_cleared = lines_q;
  assign grid          = grid_q;
  assign occ           = occ_q;

  // Collision query: anything outside the playfield reads as wall or floor.
  assign q_occ = ((q_x >= COLS_L) || (q_y >= ROWS_L)) ? 1'b1 : occ_q[q_y][q_x];

  // Next-state logic for the line-clear scan; a wipe overrides everything.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    count_d      = count_q;
    lines_d      = lines_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (lock_done) begin
          state_d = SCAN;
          r_d     = ROW_LAST;
          count_d = '0;
        end
      end
      SCAN: begin
        if (row_full) begin
          state_d = SHIFT;
          count_d = (count_q == 5'd31) ? count_q : count_q + 5'd1;
        end else if (r_q == 5'd0) begin
          // Pulse and result are registered so both are visible in DONE.
          state_d      = DONE;
          clear_done_d = 1'b1;
          lines_d      = count_q;
        end else begin
          r_d = r_q - 5'd1;
        end
      end
      SHIFT: begin
        // Pointer stays put so the row that just dropped in is re-checked.
        state_d = SCAN;
      end
      DONE: begin
        state_d = IDLE;
        r_d     = ROW_LAST;
      end
      default: begin
        state_d = IDLE;
        r_d     = ROW_LAST;
      end
    endcase
    if (clr) begin
      state_d      = IDLE;
      r_d          = ROW_LAST;
      count_d      = '0;
      lines_d      = '0;
      clear_done_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      r_q          <= ROW_LAST;
      count_q      <= '0;
      lines_q      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      count_q      <= count_d;
      lines_q      <= lines_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Board storage: wipe, one-cycle shift of rows 0..r down by one, or cell write.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      grid_q <= '0;
      occ_q  <= '0;
    end else if (clr) begin
      grid_q <= '0;
      occ_q  <= '0;
    end else if (state_q == SHIFT) begin
      for (int k = 1; k < ROWS; k++) begin
        if (k <= int'(r_q)) begin
          grid_q[k] <= grid_q[k-1];
          occ_q[k]  <= occ_q[k-1];
        end
      end
      grid_q[0] <= '0;
      occ_q[0]  <= '0;
    end else if (wr_fire) begin
      grid_q[wr_y][wr_x] <= wr_color;
      occ_q[wr_y][wr_x]  <= 1'b1;
    end
  end

endmodule

// File: doc/board_grid.md
BOARD_GRID -- requirements
Module: board_grid

Interface
REQ-001 Parameters SHALL be: COLS, default 10, playfield columns; ROWS, default 18, playfield rows; CW, default 3, color-code width.
REQ-002 vga_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 clr  in  1  synchronous board wipe.
REQ-005 wr_valid  in  1  cell-write request.
REQ-006 wr_ready  out  1  high when writes are accepted.
REQ-007 wr_x  in  4  column of the cell to write.
REQ-008 wr_y  in  5  row of the cell to write; row 0 is the top row.
REQ-009 wr_color  in  CW  color code to store.
REQ-010 lock_done  in  1  one-cycle pulse marking the piece as fully written; it starts the line-clear scan.
REQ-011 q_x  in  4  collision-query column.
REQ-012 q_y  in  5  collision-query row.
REQ-013 q_occ  out  1  combinational occupancy of cell (q_x,q_y).
REQ-014 busy  out  1  high while a scan is in progress.
REQ-015 clear_done  out  1  one-cycle pulse at the end of a scan.
REQ-016 lines_cleared  out  5  number of rows removed by the last scan.
REQ-017 grid  out  [COLS-1:0][CW-1:0] x ROWS  registered color array, indexed grid[row][col], for the color mapper.
REQ-018 occ  out  [COLS-1:0] x ROWS  registered occupancy bitmap.

Function
REQ-019 FSM states SHALL be IDLE, SCAN, SHIFT and DONE; busy SHALL be 1 in every state except IDLE, and wr_ready SHALL equal ~busy.
REQ-020 Write: in IDLE with wr_valid=1, wr_x<COLS and wr_y<ROWS, the next edge SHALL set grid[wr_y][wr_x]=wr_color and occ[wr_y][wr_x]=1.
REQ-021 Writes with out-of-range coordinates, or made while busy=1, SHALL be ignored with no state change.
REQ-022 q_occ SHALL return occ[q_y][q_x] combinationally; q_x>=COLS or q_y>=ROWS SHALL return 1 (wall/floor).
REQ-023 lock_done in IDLE SHALL move the FSM to SCAN with row pointer r=ROWS-1 and the internal count=0.
REQ-024 If lock_done and a valid write arrive in the same IDLE cycle, the write SHALL commit on that edge, and the scan SHALL see it.
REQ-025 lock_done while busy=1 SHALL be ignored.
REQ-026 SCAN, one row per cycle:
 - occ[r] all ones: go to SHIFT and increment count (saturating at 31).
 - else if r==0: go to DONE.
 - else: decrement r.
REQ-027 SHIFT SHALL, in one cycle, copy rows k-1 into rows k for every k in 1..r, clear row 0 (color 0, occ 0), and return to SCAN with r unchanged, so the row that moved down is re-checked.
REQ-028 DONE SHALL assert clear_done for exactly one cycle, load lines_cleared=count, and return to IDLE.
REQ-029 lines_cleared SHALL hold its value until the next DONE.
REQ-030 Latency: clear_done SHALL go high ROWS cycles after the edge that samples lock_done, plus 2 cycles per cleared row.
REQ-031 Rows below r SHALL never be modified during a scan.
REQ-032 A full row 0 SHALL be cleared, re-checked as empty, and then end the scan.
REQ-033 clr=1 in any state SHALL, on the next edge, set all grid and occ to 0, set lines_cleared=0, deassert clear_done, and force IDLE.
REQ-034 clr SHALL take priority over writes and lock_done in the same cycle.

Reset
REQ-035 reset_n=0 SHALL asynchronously set all grid cells to 0, all occ bits to 0, state=IDLE, r=ROWS-1, count=0, lines_cleared=0, clear_done=0, busy=0 and wr_ready=1.
REQ-036 Reset asserted mid-scan SHALL abandon the scan and leave no partial shift visible after release.
REQ-037 Operation SHALL resume on the first rising edge after reset_n returns to 1.

Verification
REQ-038 Write (3,17,3'b101), then query q=(3,17) -> q_occ=1 and grid[17][3]=5; query (10,0) -> q_occ=1; query (0,18) -> q_occ=1.
REQ-039 Fill row 17 cols 0..9 with color 2, put one cell (4,16) with color 6, pulse lock_done -> clear_done 20 cycles later, lines_cleared=1, row 17 holds only col 4=6, row 16 all empty.
REQ-040 Fill rows 16 and 17 completely, pulse lock_done -> clear_done 22 cycles later, lines_cleared=2, board empty.
REQ-041 Empty board, pulse lock_done -> clear_done after 18 cycles, lines_cleared=0; wr_valid during the scan -> wr_ready=0 and the board is unchanged.
REQ-042 Pulse clr, or pull reset_n low, 5 cycles into a scan over a full row 17 -> board all zero, busy=0, no clear_done pulse.
REQ-043 Write a valid cell together with lock_done, completing row 17 -> the row is cleared and lines_cleared=1.
